// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 7-segment scan driver with a built-in prescaler,
// double-buffered snapshot (staging -> display at frame boundary) and page select.
// Optional feature macro: SEG7_LZ_BLANK_EN (leading-zero suppression in the page).
module seg7_scan_driver #(
  parameter int DIGITS   = 4,
  parameter int PAGES    = 2,
  parameter int SCAN_DIV = 50000,
  parameter int PW       = 1
) (
  input  logic                        CLK,
  input  logic                        Reset,
  input  logic [4*DIGITS*PAGES-1:0]   Data,
  input  logic                        Load,
  input  logic [PW-1:0]               Page,
  input  logic                        Blank,
  output logic [DIGITS-1:0]           AN,
  output logic [7:0]                  Seg,
  output logic                        Busy
);

  localparam int CW  = $clog2(SCAN_DIV);
  localparam int IW  = $clog2(DIGITS);
  localparam int PGW = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic [CW-1:0]                          cnt;
  logic [IW-1:0]                          idx, idx_nxt;
  logic [PAGES-1:0][DIGITS-1:0][3:0]      stg, stg_nxt, disp, disp_nxt;
  logic [PGW-1:0]                         page_q, page_nxt, pg_in;
  logic                                   busy, busy_nxt;
  logic                                   tick, frame;
  logic [3:0]                             nib;
  logic [DIGITS-1:0]                      an_nxt;
  logic [7:0]                             seg_nxt;

  // Active-low hex font, dp off.
  function automatic logic [7:0] font(input logic [3:0] v);
    logic [7:0] s;
    s = 8'hFF;
    case (v)
      4'h0: s = 8'hC0; 4'h1: s = 8'hF9; 4'h2: s = 8'hA4; 4'h3: s = 8'hB0;
      4'h4: s = 8'h99; 4'h5: s = 8'h92; 4'h6: s = 8'h82; 4'h7: s = 8'hF8;
      4'h8: s = 8'h80; 4'h9: s = 8'h90; 4'hA: s = 8'h88; 4'hB: s = 8'h83;
      4'hC: s = 8'hC6; 4'hD: s = 8'hA1; 4'hE: s = 8'h86; 4'hF: s = 8'h8E;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // Scan timing, snapshot commit and page latch for the coming edge.
  always_comb begin
    tick     = (cnt == CW'(SCAN_DIV - 1));
    frame    = tick && (idx == IW'(DIGITS - 1));
    idx_nxt  = idx;
    if (tick) idx_nxt = (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
    // Out-of-range page requests fall back to page 0; clamp once at the latch.
    pg_in    = (32'(Page) < PAGES) ? PGW'(Page) : '0;
    stg_nxt  = stg;
    disp_nxt = disp;
    busy_nxt = busy;
    page_nxt = page_q;
    if (frame) begin
      page_nxt = pg_in;
      busy_nxt = 1'b0;
      if (Load) begin
        // Load coinciding with the boundary bypasses staging entirely.
        stg_nxt  = Data;
        disp_nxt = Data;
      end else if (busy) begin
        disp_nxt = stg;
      end
    end else if (Load) begin
      stg_nxt  = Data;
      busy_nxt = 1'b1;
    end
  end

`ifdef SEG7_LZ_BLANK_EN
  // zfrom[i]: nibbles i..DIGITS-1 of the page about to be shown are all zero.
  logic [DIGITS-1:0] zfrom;
  logic              lz_dark;
  for (genvar g = 0; g < DIGITS; g++) begin : g_lz
    assign zfrom[g] = (disp_nxt[page_nxt][DIGITS-1:g] == '0);
  end
  assign lz_dark = (idx_nxt != '0) && zfrom[idx_nxt];
`endif

  // Digit decode uses post-edge idx/display/page so digit 0 of a frame is fresh.
  always_comb begin
    nib             = disp_nxt[page_nxt][idx_nxt];
    an_nxt          = '1;
    an_nxt[idx_nxt] = 1'b0;
    seg_nxt         = font(nib);
`ifdef SEG7_LZ_BLANK_EN
    if (lz_dark) begin
      an_nxt  = '1;
      seg_nxt = 8'hFF;
    end
`endif
  end

  // Prescaler, scan index and snapshot buffers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      cnt    <= '0;
      idx    <= IW'(DIGITS - 1);
      stg    <= '0;
      disp   <= '0;
      busy   <= 1'b0;
      page_q <= '0;
    end else begin
      cnt    <= tick ? '0 : cnt + 1'b1;
      idx    <= idx_nxt;
      stg    <= stg_nxt;
      disp   <= disp_nxt;
      busy   <= busy_nxt;
      page_q <= page_nxt;
    end
  end

  // Registered digit outputs: dark on Blank, refreshed on tick, held otherwise.
  always_ff @(posedge CLK) begin
    if (Reset || Blank) begin
      AN  <= '1;
      Seg <= 8'hFF;
    end else if (tick) begin
      AN  <= an_nxt;
      Seg <= seg_nxt;
    end
  end

  assign Busy = busy;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed scenarios plus random traffic, every cycle
// compared against an arithmetic model (edge count since reset -> tick/digit).
module tb_seg7_scan_driver;

  localparam int DIGITS   = 4;
  localparam int PAGES    = 2;
  localparam int SCAN_DIV = 4;
  localparam int PW       = 2;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Data = '0;
  logic        Load = 1'b0;
  logic [1:0]  Page = '0;
  logic        Blank = 1'b0;
  logic [3:0]  AN;
  logic [7:0]  Seg;
  logic        Busy;

  seg7_scan_driver #(.DIGITS(DIGITS), .PAGES(PAGES), .SCAN_DIV(SCAN_DIV), .PW(PW)) dut (
    .CLK(CLK), .Reset(Reset), .Data(Data), .Load(Load), .Page(Page),
    .Blank(Blank), .AN(AN), .Seg(Seg), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  logic [7:0] font_t [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  int n_vec = 0;
  int n_bad = 0;

  // Model state: e = edges since reset released.
  int          e;
  int          m_idx, m_pg;
  logic [31:0] m_stg, m_disp;
  logic        m_busy;
  logic [3:0]  m_an;
  logic [7:0]  m_seg;
  logic [1:0]  cur_pg = '0;
  logic        cur_bl = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s e=%0d got=%h exp=%h", tag, e, got, exp);
    end
  endtask

  task automatic model(input bit r, input logic [31:0] d, input bit ld,
                       input logic [1:0] pg, input bit bl);
    bit          tick, frame;
    logic [15:0] pw;
    if (r) begin
      e = 0; m_idx = DIGITS - 1; m_pg = 0;
      m_stg = '0; m_disp = '0; m_busy = 1'b0;
      m_an = 4'hF; m_seg = 8'hFF;
      return;
    end
    e++;
    tick  = (e % SCAN_DIV) == 0;
    if (tick) m_idx = ((e / SCAN_DIV) - 1) % DIGITS;
    frame = tick && (m_idx == 0);
    if (frame) begin
      if (ld) begin m_disp = d; m_stg = d; end
      else if (m_busy) m_disp = m_stg;
      m_busy = 1'b0;
      m_pg = (int'(pg) < PAGES) ? int'(pg) : 0;
    end else if (ld) begin
      m_stg = d; m_busy = 1'b1;
    end
    if (bl) begin
      m_an = 4'hF; m_seg = 8'hFF;
    end else if (tick) begin
      pw    = 16'(m_disp >> (16 * m_pg));
      m_an  = 4'hF & ~(4'b1 << m_idx);
      m_seg = font_t[4'(pw >> (4 * m_idx))];
`ifdef SEG7_LZ_BLANK_EN
      if (m_idx > 0 && (pw >> (4 * m_idx)) == 0) begin
        m_an = 4'hF; m_seg = 8'hFF;
      end
`endif
    end
  endtask

  task automatic step(input bit r, input logic [31:0] d, input bit ld,
                      input logic [1:0] pg, input bit bl);
    @(negedge CLK);
    Reset = r; Data = d; Load = ld; Page = pg; Blank = bl;
    @(posedge CLK);
    model(r, d, ld, pg, bl);
    #1;
    chk("an", 32'(AN), 32'(m_an));
    chk("seg", 32'(Seg), 32'(m_seg));
    chk("busy", 32'(Busy), 32'(m_busy));
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 1000 && e < t; i++) step(1'b0, $urandom, 1'b0, cur_pg, cur_bl);
  endtask

  initial begin
    // Reset held 3 cycles, first tick on the 4th edge after release.
    for (int i = 0; i < 3; i++) step(1'b1, '0, 1'b0, 2'd0, 1'b0);
    chk("rst_an", 32'(AN), 32'hF);
    chk("rst_seg", 32'(Seg), 32'hFF);
    run_to(3);
    chk("pre_tick_an", 32'(AN), 32'hF);
    run_to(4);
    chk("tick1_an", 32'(AN), 32'hE);
    chk("tick1_seg", 32'(Seg), 32'hC0);

    // Mid-frame load, committed at next boundary; page 0 then page 1.
    step(1'b0, 32'h12345678, 1'b1, cur_pg, cur_bl);
    chk("ld_busy", 32'(Busy), 32'h1);
    run_to(20); chk("p0d0", 32'(Seg), 32'h80); chk("p0_busy", 32'(Busy), 32'h0);
    run_to(24); chk("p0d1", 32'(Seg), 32'hF8);
    run_to(28); chk("p0d2", 32'(Seg), 32'h82);
    run_to(32); chk("p0d3", 32'(Seg), 32'h92); chk("p0d3_an", 32'(AN), 32'h7);
    cur_pg = 2'd1;
    run_to(36); chk("p1d0", 32'(Seg), 32'h99);
    run_to(40); chk("p1d1", 32'(Seg), 32'hB0);

    // Overwrite while showing: old digits persist until the boundary.
    step(1'b0, 32'hFFFFFFFF, 1'b1, cur_pg, cur_bl);
    chk("ov_busy", 32'(Busy), 32'h1);
    run_to(44); chk("ov_old", 32'(Seg), 32'hA4);
    run_to(52); chk("ov_busy0", 32'(Busy), 32'h0); chk("ov_new", 32'(Seg), 32'h8E);

    // Blank mid-frame, then release; next tick shows digit 1.
    cur_bl = 1'b1;
    run_to(53); chk("blank_an", 32'(AN), 32'hF); chk("blank_seg", 32'(Seg), 32'hFF);
    run_to(54);
    cur_bl = 1'b0;
    run_to(55); chk("blank_hold", 32'(AN), 32'hF);
    run_to(56); chk("unblank_an", 32'(AN), 32'hD); chk("unblank_seg", 32'(Seg), 32'h8E);

    // Out-of-range page falls back to page 0 at the next boundary.
    cur_pg = 2'd3;
    run_to(68); chk("pg3_d0", 32'(Seg), 32'h8E); chk("pg3_an", 32'(AN), 32'hE);

    // Reset during digit 2.
    run_to(76); chk("d2_an", 32'(AN), 32'hB);
    step(1'b1, '0, 1'b0, 2'd0, 1'b0);
    chk("mid_rst_an", 32'(AN), 32'hF); chk("mid_rst_busy", 32'(Busy), 32'h0);
    cur_pg = 2'd0;
    run_to(4); chk("post_rst_seg", 32'(Seg), 32'hC0);

    // Leading-zero case.
    step(1'b1, '0, 1'b0, 2'd0, 1'b0);
    step(1'b0, 32'h000000A0, 1'b1, 2'd0, 1'b0);
    run_to(4);  chk("lz_d0", 32'(Seg), 32'hC0);
    run_to(8);  chk("lz_d1", 32'(Seg), 32'h88);
    run_to(12);
`ifdef SEG7_LZ_BLANK_EN
    chk("lz_d2_an", 32'(AN), 32'hF); chk("lz_d2_seg", 32'(Seg), 32'hFF);
`else
    chk("lz_d2_an", 32'(AN), 32'hB); chk("lz_d2_seg", 32'(Seg), 32'hC0);
`endif

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      bit          r, ld;
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d & ($urandom_range(0, 1) ? 32'h0000_00FF : 32'h00FF_00F0);
      r  = ($urandom_range(0, 299) == 0);
      ld = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 29) == 0) cur_bl = ~cur_bl;
      if ($urandom_range(0, 39) == 0) cur_pg = 2'($urandom_range(0, 3));
      step(r, d, ld, cur_pg, cur_bl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
